// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for a fixed-latency memory read port
module mem_arbiter #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4,
  parameter int LATENCY   = 1,
  localparam int DW       = (2 ** MEM_EXTRA) * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic [MEM_DEPTH:0]   a_addr,
  input  logic [MEM_EXTRA-1:0] a_extra,
  output logic                 a_gnt,
  output logic                 a_valid,
  output logic [DW-1:0]        a_data,
  output logic                 a_error,
  input  logic                 b_req,
  input  logic [MEM_DEPTH:0]   b_addr,
  input  logic [MEM_EXTRA-1:0] b_extra,
  output logic                 b_gnt,
  output logic                 b_valid,
  output logic [DW-1:0]        b_data,
  output logic                 b_error,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_error,
  output logic                 busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  // 1 = port B holds the most recent grant; also identifies the owner of the in-flight access
  logic          last_grant;
  logic          pick_b;

  // On a tie the port that did not win last time is chosen
  assign pick_b = b_req & (~a_req | ~last_grant);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and the grant/valid/busy strobes decoded from the state
  always_comb begin
    next_state = state;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (a_req | b_req) next_state = ISSUE;
      ISSUE: begin
        next_state = WAIT;
        a_gnt      = ~last_grant;
        b_gnt      = last_grant;
      end
      WAIT:  if (cnt == '0) next_state = RESP;
      RESP:  begin
        next_state = IDLE;
        a_valid    = ~last_grant;
        b_valid    = last_grant;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: winner capture, memory address register, latency counter, response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_extra  <= '0;
      cnt        <= '0;
      a_data     <= '0;
      a_error    <= 1'b0;
      b_data     <= '0;
      b_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            last_grant <= pick_b;
            mem_addr   <= pick_b ? b_addr  : a_addr;
            mem_extra  <= pick_b ? b_extra : a_extra;
          end
        end
        ISSUE: cnt <= CW'(LATENCY - 1);
        WAIT: begin
          if (cnt == '0) begin
            if (last_grant) begin
              b_data  <= mem_data;
              b_error <= mem_error;
            end else begin
              a_data  <= mem_data;
              a_error <= mem_error;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MEM_DEPTH = 4;
  localparam int MEM_EXTRA = 4;
  localparam int LATENCY   = 1;
  localparam int DW        = 128;
  localparam int ROM_WORDS = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 a_req = 1'b0, b_req = 1'b0;
  logic [MEM_DEPTH:0]   a_addr = '0, b_addr = '0;
  logic [MEM_EXTRA-1:0] a_extra = 4'h3, b_extra = 4'h5;
  logic                 a_gnt, a_valid, a_error, b_gnt, b_valid, b_error, busy;
  logic [DW-1:0]        a_data, b_data, mem_data;
  logic [MEM_DEPTH:0]   mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic                 mem_error;

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_extra(a_extra), .a_gnt(a_gnt),
    .a_valid(a_valid), .a_data(a_data), .a_error(a_error),
    .b_req(b_req), .b_addr(b_addr), .b_extra(b_extra), .b_gnt(b_gnt),
    .b_valid(b_valid), .b_data(b_data), .b_error(b_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data),
    .mem_error(mem_error), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [MEM_DEPTH:0] a);
    return {4{16'hC0DE, 11'h0, a}};
  endfunction

  // One-cycle registered ROM; addresses past the end return zero with an error
  always @(posedge clk) begin
    mem_data  <= (mem_addr < ROM_WORDS) ? rom_word(mem_addr) : '0;
    mem_error <= (mem_addr >= ROM_WORDS);
  end

  typedef struct packed {
    logic                 port;
    logic [MEM_DEPTH:0]   addr;
    logic [MEM_EXTRA-1:0] extra;
    logic [DW-1:0]        data;
    logic                 err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0, passed = 0;
  int   a_gnt_cyc = 0, b_gnt_cyc = 0, a_valid_cyc = 0, a_valid_cnt = 0;
  bit   gnt_log[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Monitor: grant bookkeeping and scoreboard comparison on every valid pulse
  always @(negedge clk) begin
    if (a_gnt) begin a_gnt_cyc = cyc; gnt_log.push_back(1'b0); end
    if (b_gnt) begin b_gnt_cyc = cyc; gnt_log.push_back(1'b1); end
    if (a_gnt || b_gnt) chk("gnt_onehot", DW'(a_gnt & b_gnt), '0);
    if (a_valid) begin a_valid_cyc = cyc; a_valid_cnt++; end
    if (a_valid || b_valid) begin
      exp_t e;
      chk("valid_onehot", DW'(a_valid & b_valid), '0);
      if (q.size() == 0) begin
        chk("valid_unexpected", DW'(1), DW'(0));
      end else begin
        e = q.pop_front();
        chk("resp_port",  DW'(b_valid), DW'(e.port));
        chk("resp_data",  b_valid ? b_data : a_data, e.data);
        chk("resp_error", DW'(b_valid ? b_error : a_error), DW'(e.err));
        chk("mem_addr",   DW'(mem_addr), DW'(e.addr));
        chk("mem_extra",  DW'(mem_extra), DW'(e.extra));
      end
    end
  end

  // Raise a request, hold it until granted, then drop it; the expected response is queued at grant
  task automatic request(input bit port, input logic [MEM_DEPTH:0] addr, input bit expect_resp);
    exp_t e;
    bit   got = 1'b0;
    e.port  = port;
    e.addr  = addr;
    e.extra = port ? b_extra : a_extra;
    e.data  = (addr < ROM_WORDS) ? rom_word(addr) : '0;
    e.err   = (addr >= ROM_WORDS);
    if (port) begin b_req = 1'b1; b_addr = addr; end
    else      begin a_req = 1'b1; a_addr = addr; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (port ? b_gnt : a_gnt) begin
        got = 1'b1;
        if (expect_resp) q.push_back(e);
        if (port) b_req = 1'b0; else a_req = 1'b0;
        // Changing the address after grant must not affect the access
        if (port) b_addr = ~addr; else a_addr = ~addr;
      end
    end
    if (!got) begin
      chk("gnt_timeout", DW'(0), DW'(1));
      if (port) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", DW'(0), DW'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int req_cyc;
    int vcnt;
    // 1: reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   DW'({a_gnt, b_gnt}), '0);
    chk("rst_valid", DW'({a_valid, b_valid}), '0);
    chk("rst_busy",  DW'(busy), '0);
    chk("rst_addr",  DW'(mem_addr), '0);
    chk("rst_adata", a_data, '0);
    chk("rst_bdata", b_data, '0);
    reset = 1'b0;

    // 2: single A access with latency check
    @(negedge clk);
    req_cyc = cyc;
    request(1'b0, 5'd5, 1'b1);
    wait_idle();
    chk("a_gnt_latency",   DW'(a_gnt_cyc - req_cyc), DW'(1));
    chk("a_valid_latency", DW'(a_valid_cyc - a_gnt_cyc), DW'(2));
    chk("b_data_untouched", b_data, '0);

    // 3: both held from the same edge, alternating service A,B,A,B
    do_reset();
    gnt_log.delete();
    fork
      begin request(1'b0, 5'd3, 1'b1); request(1'b0, 5'd7, 1'b1); end
      begin request(1'b1, 5'd9, 1'b1); request(1'b1, 5'd12, 1'b1); end
    join
    wait_idle();
    chk("rr_count", DW'(gnt_log.size()), DW'(4));
    if (gnt_log.size() == 4)
      chk("rr_order", DW'({gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}), DW'(4'b0101));

    // 4: B arrives while A is waiting on memory
    fork
      request(1'b0, 5'd2, 1'b1);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (a_gnt) seen = 1'b1;
        end
        @(negedge clk);
        chk("busy_in_wait", DW'(busy), DW'(1));
        request(1'b1, 5'd4, 1'b1);
      end
    join
    wait_idle();
    chk("b_after_a_resp", DW'(b_gnt_cyc - a_valid_cyc), DW'(2));

    // 5: out-of-range address reports an error, next clean access does not
    request(1'b0, 5'd20, 1'b1);
    wait_idle();
    request(1'b0, 5'd6, 1'b1);
    wait_idle();
    chk("error_cleared", DW'(a_error), DW'(0));

    // 6: reset while waiting drops the response
    request(1'b0, 5'd1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vcnt = a_valid_cnt;
    chk("rst_mid_busy",  DW'(busy), '0);
    chk("rst_mid_adata", a_data, '0);
    repeat (6) @(negedge clk);
    chk("rst_mid_novalid", DW'(a_valid_cnt - vcnt), '0);
    request(1'b0, 5'd6, 1'b1);
    wait_idle();
    chk("scoreboard_empty", DW'(q.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
